// File: rtl/fu_mem_pkg.sv
// Shared width codes and lane helpers for the memory functional unit.
// Used by fu_mem_pipe; the MISALIGN_TRAP_EN build option lives in the top.
package fu_mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

  // Unknown width codes fall into the word class.
  function automatic mem_size_e size_of(input logic [2:0] f3);
    case (f3)
      MEM_B, MEM_BU: size_of = SZ_B;
      MEM_H, MEM_HU: size_of = SZ_H;
      default:       size_of = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input mem_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    byte_en = 4'b0001 << lo;
      SZ_H:    byte_en = 4'b0011 << {lo[1], 1'b0};
      default: byte_en = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input mem_size_e sz, input logic [31:0] d);
    case (sz)
      SZ_B:    store_lanes = {4{d[7:0]}};
      SZ_H:    store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [31:0] bsh;
    logic [31:0] hsh;
    bsh = word >> {lo, 3'b000};
    hsh = word >> {lo[1], 4'b0000};
    case (f3)
      MEM_B:   load_extend = {{24{bsh[7]}}, bsh[7:0]};
      MEM_BU:  load_extend = {24'h0, bsh[7:0]};
      MEM_H:   load_extend = {{16{hsh[15]}}, hsh[15:0]};
      MEM_HU:  load_extend = {16'h0, hsh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_ram_be.sv
// Single-port data RAM with per-byte write enables and registered read.
module mem_ram_be #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fu_mem_pipe.sv
// Memory functional unit: issue capture, RAM access, extend, LATENCY-deep completion pipe.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of truncating the address.
module fu_mem_pipe
  import fu_mem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 2,
  parameter int TAG_W     = 4,
  parameter int PIPELINED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  output logic             ready,
  input  logic             mem_w,
  input  logic [2:0]       bhw,
  input  logic [TAG_W-1:0] tag,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  output logic             finish,
  output logic [TAG_W-1:0] finish_tag,
  output logic [XLEN-1:0]  mem_data,
  output logic             exc
);

  logic            fire;
  logic [XLEN-1:0] addr_sum;
  logic            mis_issue;
  logic            unused_addr_hi;

  logic              s0_st_q, s0_st_d;
  logic [2:0]        s0_f3_q, s0_f3_d;
  logic [ADDR_W+1:0] s0_addr_q, s0_addr_d;
  logic [XLEN-1:0]   s0_wdata_q, s0_wdata_d;
  logic              s1_st_q, s1_st_d;
  logic [2:0]        s1_f3_q, s1_f3_d;
  logic [1:0]        s1_lo_q, s1_lo_d;

  logic [LATENCY-1:0]            vld_q, vld_d;
  logic [LATENCY-1:0]            exc_q, exc_d;
  logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d;

  logic             fin_q, fin_d;
  logic [TAG_W-1:0] fin_tag_q, fin_tag_d;
  logic [XLEN-1:0]  fin_data_q, fin_data_d;
  logic             fin_exc_q, fin_exc_d;

  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [XLEN-1:0] dat_w [LATENCY-1];

  // Non-pipelined mode: busy from accept until the finish cycle, when the pipe is empty again.
  assign ready    = (PIPELINED != 0) ? 1'b1 : ~|vld_q;
  assign fire     = EN & ready;
  assign addr_sum = rs1_data + imm;
  assign unused_addr_hi = ^addr_sum[XLEN-1:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    mis_issue = 1'b0;
    case (size_of(bhw))
      SZ_H:    mis_issue = addr_sum[0];
      SZ_W:    mis_issue = |addr_sum[1:0];
      default: mis_issue = 1'b0;
    endcase
  end
`else
  assign mis_issue = 1'b0;
`endif

  always_comb begin
    s0_st_d    = s0_st_q;
    s0_f3_d    = s0_f3_q;
    s0_addr_d  = s0_addr_q;
    s0_wdata_d = s0_wdata_q;
    if (fire) begin
      s0_st_d    = mem_w;
      s0_f3_d    = bhw;
      s0_addr_d  = addr_sum[ADDR_W+1:0];
      s0_wdata_d = rs2_data;
    end
    s1_st_d    = s0_st_q;
    s1_f3_d    = s0_f3_q;
    s1_lo_d    = s0_addr_q[1:0];
    vld_d      = {vld_q[LATENCY-2:0], fire};
    exc_d      = {exc_q[LATENCY-2:0], mis_issue};
    tag_d      = {tag_q[LATENCY-2:0], tag};
    fin_d      = vld_q[LATENCY-1];
    fin_tag_d  = vld_q[LATENCY-1] ? tag_q[LATENCY-1] : '0;
    fin_data_d = vld_q[LATENCY-1] ? dat_w[LATENCY-2] : '0;
    fin_exc_d  = vld_q[LATENCY-1] & exc_q[LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_st_q    <= 1'b0;
      s0_f3_q    <= '0;
      s0_addr_q  <= '0;
      s0_wdata_q <= '0;
      s1_st_q    <= 1'b0;
      s1_f3_q    <= '0;
      s1_lo_q    <= '0;
      vld_q      <= '0;
      exc_q      <= '0;
      tag_q      <= '0;
      fin_q      <= 1'b0;
      fin_tag_q  <= '0;
      fin_data_q <= '0;
      fin_exc_q  <= 1'b0;
    end else begin
      s0_st_q    <= s0_st_d;
      s0_f3_q    <= s0_f3_d;
      s0_addr_q  <= s0_addr_d;
      s0_wdata_q <= s0_wdata_d;
      s1_st_q    <= s1_st_d;
      s1_f3_q    <= s1_f3_d;
      s1_lo_q    <= s1_lo_d;
      vld_q      <= vld_d;
      exc_q      <= exc_d;
      tag_q      <= tag_d;
      fin_q      <= fin_d;
      fin_tag_q  <= fin_tag_d;
      fin_data_q <= fin_data_d;
      fin_exc_q  <= fin_exc_d;
    end
  end

  // Writes are gated by the stage-0 valid, so a reset before the access edge drops the store.
  assign ram_we    = vld_q[0] & s0_st_q & ~exc_q[0];
  assign ram_be    = byte_en(size_of(s0_f3_q), s0_addr_q[1:0]);
  assign ram_wdata = store_lanes(size_of(s0_f3_q), s0_wdata_q);

  mem_ram_be #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (vld_q[0]),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (s0_addr_q[ADDR_W+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign dat_w[0] = (s1_st_q | exc_q[1]) ? '0 : load_extend(s1_f3_q, s1_lo_q, ram_rdata);

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY - 1; gi++) begin : g_dly
      logic [XLEN-1:0] dat_q;
      logic [XLEN-1:0] dat_d;
      assign dat_d = dat_w[gi-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dat_q <= '0;
        else        dat_q <= dat_d;
      end
      assign dat_w[gi] = dat_q;
    end
  endgenerate

  assign finish     = fin_q;
  assign finish_tag = fin_tag_q;
  assign mem_data   = fin_data_q;
  assign exc        = fin_exc_q;

endmodule

// File: tb/tb_fu_mem_pipe.sv
// Directed self-checking bench: default unit, a LATENCY=4 pipelined unit and a non-pipelined unit.
module tb_fu_mem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en, en4, en_np;
  logic        mem_w;
  logic [2:0]  bhw;
  logic [3:0]  tag;
  logic [31:0] rs1, rs2, imm;

  logic        rdy, fin, exc;
  logic [3:0]  fin_tag;
  logic [31:0] mdata;
  logic        rdy4, fin4, exc4;
  logic [3:0]  fin_tag4;
  logic [31:0] mdata4;
  logic        rdy_np, fin_np, exc_np;
  logic [3:0]  fin_tag_np;
  logic [31:0] mdata_np;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_tag[$];
  logic [31:0] q_dat[$];
  int          q_k[$];
  int          acc_k[$];
  int          fin_k[$];
  int          rlow4;
  int          fin_cnt;

  fu_mem_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .EN(en), .ready(rdy), .mem_w(mem_w), .bhw(bhw), .tag(tag),
    .rs1_data(rs1), .rs2_data(rs2), .imm(imm), .finish(fin), .finish_tag(fin_tag),
    .mem_data(mdata), .exc(exc)
  );

  fu_mem_pipe #(.LATENCY(4), .PIPELINED(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .EN(en4), .ready(rdy4), .mem_w(mem_w), .bhw(bhw), .tag(tag),
    .rs1_data(rs1), .rs2_data(rs2), .imm(imm), .finish(fin4), .finish_tag(fin_tag4),
    .mem_data(mdata4), .exc(exc4)
  );

  fu_mem_pipe #(.LATENCY(3), .PIPELINED(0)) u_dut_np (
    .clk(clk), .rst_n(rst_n), .EN(en_np), .ready(rdy_np), .mem_w(mem_w), .bhw(bhw), .tag(tag),
    .rs1_data(rs1), .rs2_data(rs2), .imm(imm), .finish(fin_np), .finish_tag(fin_tag_np),
    .mem_data(mdata_np), .exc(exc_np)
  );

  task automatic check_eq(input string tg, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tg, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tg, got);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [3:0] t,
                       input logic [31:0] a, input logic [31:0] im, input logic [31:0] d);
    mem_w = w; bhw = f3; tag = t; rs1 = a; imm = im; rs2 = d;
  endtask

  // One op on the default unit: accept, then expect finish exactly 2 edges later.
  task automatic run_op(input string nm, input logic w, input logic [2:0] f3, input logic [3:0] t,
                        input logic [31:0] a, input logic [31:0] im, input logic [31:0] d,
                        input logic [31:0] exp);
    int n;
    bit seen;
    drive(w, f3, t, a, im, d);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (fin) seen = 1'b1;
    end
    check_eq({nm, "_lat"}, 32'(n - 1), 32'd2);
    check_eq({nm, "_tag"}, {28'h0, fin_tag}, {28'h0, t});
    check_eq({nm, "_data"}, mdata, exp);
    check_eq({nm, "_exc"}, {31'h0, exc}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; en4 = 1'b0; en_np = 1'b0;
    drive(1'b0, 3'b000, 4'h0, 32'h0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {31'h0, rdy}, 32'h1);
    check_eq("rst_finish", {31'h0, fin}, 32'h0);
    check_eq("rst_tag", {28'h0, fin_tag}, 32'h0);
    check_eq("rst_data", mdata, 32'h0);
    check_eq("rst_exc", {31'h0, exc}, 32'h0);
    check_eq("rst_ready_np", {31'h0, rdy_np}, 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // store then load, same word
    run_op("sw104", 1'b1, 3'b010, 4'd1, 32'h100, 32'h4, 32'hDEADBEEF, 32'h0);
    run_op("lw104", 1'b0, 3'b010, 4'd2, 32'h104, 32'h0, 32'h0, 32'hDEADBEEF);

    // byte store and extends
    run_op("sw100", 1'b1, 3'b010, 4'd3, 32'h100, 32'h0, 32'h11223344, 32'h0);
    run_op("sb101", 1'b1, 3'b000, 4'd4, 32'h101, 32'h0, 32'h12345680, 32'h0);
    run_op("lb101", 1'b0, 3'b000, 4'd5, 32'h101, 32'h0, 32'h0, 32'hFFFFFF80);
    run_op("lbu101", 1'b0, 3'b100, 4'd6, 32'h101, 32'h0, 32'h0, 32'h00000080);
    run_op("lw100", 1'b0, 3'b010, 4'd7, 32'h100, 32'h0, 32'h0, 32'h11228044);
    run_op("lh100", 1'b0, 3'b001, 4'd8, 32'h100, 32'h0, 32'h0, 32'hFFFF8044);
    run_op("lhu102", 1'b0, 3'b101, 4'd9, 32'h102, 32'h0, 32'h0, 32'h00001122);

    // address wrap, negative offset, illegal width codes
    run_op("lw_wrap", 1'b0, 3'b010, 4'd10, 32'h10001104, 32'h0, 32'h0, 32'hDEADBEEF);
    run_op("lw_negimm", 1'b0, 3'b010, 4'd11, 32'h108, 32'hFFFFFFFC, 32'h0, 32'hDEADBEEF);
    run_op("ill011", 1'b0, 3'b011, 4'd12, 32'h104, 32'h0, 32'h0, 32'hDEADBEEF);
    run_op("ill111", 1'b0, 3'b111, 4'd13, 32'h104, 32'h0, 32'h0, 32'hDEADBEEF);

    // halfword store
    run_op("sh106", 1'b1, 3'b001, 4'd14, 32'h106, 32'h0, 32'h9999ABCD, 32'h0);
    run_op("lh106", 1'b0, 3'b001, 4'd15, 32'h106, 32'h0, 32'h0, 32'hFFFFABCD);
    run_op("lw104b", 1'b0, 3'b010, 4'd0, 32'h104, 32'h0, 32'h0, 32'hABCDBEEF);

    // misaligned accesses truncate to natural alignment
    run_op("lh103", 1'b0, 3'b001, 4'd1, 32'h103, 32'h0, 32'h0, 32'h00001122);
    run_op("sw103", 1'b1, 3'b010, 4'd2, 32'h103, 32'h0, 32'h55667788, 32'h0);
    run_op("lw100b", 1'b0, 3'b010, 4'd3, 32'h100, 32'h0, 32'h0, 32'h55667788);

    // back-to-back store then load to the same word
    drive(1'b1, 3'b010, 4'd3, 32'h200, 32'h0, 32'hCAFEF00D);
    en = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 3'b010, 4'd4, 32'h200, 32'h0, 32'h0);
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    check_eq("b2b_gap", {31'h0, fin}, 32'h0);
    @(negedge clk);
    check_eq("b2b_st_fin", {31'h0, fin}, 32'h1);
    check_eq("b2b_st_tag", {28'h0, fin_tag}, 32'd3);
    @(negedge clk);
    check_eq("b2b_ld_fin", {31'h0, fin}, 32'h1);
    check_eq("b2b_ld_tag", {28'h0, fin_tag}, 32'd4);
    check_eq("b2b_ld_data", mdata, 32'hCAFEF00D);

    // LATENCY=4 pipelined unit: 8 stores then 8 loads, every cycle
    rlow4 = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          if (i < 8) drive(1'b1, 3'b010, 4'(i + 8), 32'(4 * i), 32'h0, 32'(i + 1) * 32'h01010101);
          else       drive(1'b0, 3'b010, 4'(i - 8), 32'(4 * (i - 8)), 32'h0, 32'h0);
          en4 = 1'b1;
          @(posedge clk); #1;
        end
        en4 = 1'b0;
      end
      begin
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (!rdy4) rlow4++;
          if (fin4) begin
            q_tag.push_back({28'h0, fin_tag4});
            q_dat.push_back(mdata4);
            q_k.push_back(k);
          end
        end
      end
    join
    check_eq("p4_ready_low", 32'(rlow4), 32'd0);
    check_eq("p4_count", 32'(q_tag.size()), 32'd16);
    for (int j = 0; j < q_tag.size(); j++) begin
      if (j < 8) begin
        check_eq($sformatf("p4_st_tag%0d", j), q_tag[j], 32'(j + 8));
        check_eq($sformatf("p4_st_data%0d", j), q_dat[j], 32'h0);
      end else begin
        check_eq($sformatf("p4_ld_tag%0d", j - 8), q_tag[j], 32'(j - 8));
        check_eq($sformatf("p4_ld_data%0d", j - 8), q_dat[j], 32'(j - 7) * 32'h01010101);
      end
      check_eq($sformatf("p4_when%0d", j), 32'(q_k[j]), 32'(5 + j));
    end

    // non-pipelined LATENCY=3 unit with EN held: accept, 3 busy cycles, accept in finish cycle
    @(posedge clk); #1;
    drive(1'b0, 3'b010, 4'd5, 32'h104, 32'h0, 32'h0);
    en_np = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (rdy_np) acc_k.push_back(k);
      if (fin_np) begin
        fin_k.push_back(k);
        check_eq($sformatf("np_tag_k%0d", k), {28'h0, fin_tag_np}, 32'd5);
      end
    end
    @(posedge clk); #1;
    en_np = 1'b0;
    check_eq("np_acc_count", 32'(acc_k.size()), 32'd4);
    for (int j = 0; j < acc_k.size(); j++)
      check_eq($sformatf("np_acc%0d", j), 32'(acc_k[j]), 32'(4 * j));
    check_eq("np_fin_count", 32'(fin_k.size()), 32'd3);
    for (int j = 0; j < fin_k.size(); j++)
      check_eq($sformatf("np_fin%0d", j), 32'(fin_k[j]), 32'(4 * (j + 1)));
    repeat (6) @(posedge clk);
    #1;

    // reset right after a store accept: the store must vanish
    run_op("sw300", 1'b1, 3'b010, 4'd6, 32'h300, 32'h0, 32'h12345678, 32'h0);
    drive(1'b1, 3'b010, 4'd7, 32'h300, 32'h0, 32'hBADBADBA);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fin_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (fin) fin_cnt++;
    end
    check_eq("rst_drop_fin", 32'(fin_cnt), 32'd0);
    check_eq("rst_drop_ready", {31'h0, rdy}, 32'h1);
    run_op("lw300", 1'b0, 3'b010, 4'd8, 32'h300, 32'h0, 32'h0, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
